// File: rtl/ft245_sync_device_if.sv
// ft245_sync_device_if: synchronous FT245 FIFO bus between the FPGA master and the device responder
interface ft245_sync_device_if;
  logic       ft_rxf_n;
  logic       ft_txe_n;
  logic       ft_oe_n;
  logic       ft_rd_n;
  logic       ft_wr_n;
  logic       ft_siwu_n;
  logic [7:0] ft_bus_in;
  logic [7:0] ft_bus_out;
  logic       ft_bus_oe;
  modport master (
    input  ft_rxf_n, ft_txe_n, ft_bus_out, ft_bus_oe,
    output ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n, ft_bus_in
  );
  modport slave (
    output ft_rxf_n, ft_txe_n, ft_bus_out, ft_bus_oe,
    input  ft_oe_n, ft_rd_n, ft_wr_n, ft_siwu_n, ft_bus_in
  );
endinterface

// File: rtl/ft245_sync_device.sv
// ft245_sync_device: FTDI-side responder for the synchronous FT245 bus with host-side RX/TX FIFOs
module ft245_sync_device #(
  parameter int AW       = 4,
  parameter int TXE_HOLD = 0
) (
  input  logic                 ft_clkout,
  input  logic                 rst,
  ft245_sync_device_if.slave   ft,
  input  logic [7:0]           host_wdata,
  input  logic                 host_wvalid,
  output logic                 host_wready,
  output logic [7:0]           host_rdata,
  output logic                 host_rvalid,
  input  logic                 host_rready,
  output logic                 host_flush,
  output logic [2:0]           err
);
  localparam int D = 1 << AW;
  localparam logic [AW:0] FULL = (AW+1)'(D);
  logic [7:0]    rx_mem [D];
  logic [7:0]    tx_mem [D];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [AW:0]   rx_cnt, tx_cnt, rx_cnt_nx, tx_cnt_nx;
  logic [1:0]    hold_cnt, hold_nx;
  logic          rx_push, rx_pop, tx_push, tx_pop;
  assign host_wready = rx_cnt != FULL;
  assign host_rvalid = tx_cnt != '0;
  assign host_rdata  = host_rvalid ? tx_mem[tx_rp] : '0;
  assign ft.ft_bus_out = rx_cnt != '0 ? rx_mem[rx_rp] : '0;
  assign rx_push = host_wvalid & host_wready;
  assign rx_pop  = ~ft.ft_rd_n & ~ft.ft_oe_n & ~ft.ft_rxf_n & ft.ft_wr_n;
  assign tx_push = ~ft.ft_wr_n & ~ft.ft_txe_n & ft.ft_rd_n;
  assign tx_pop  = host_rvalid & host_rready;
  always_comb begin
    rx_cnt_nx = rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    tx_cnt_nx = tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    // hold timer reloads on the cycle the TX FIFO drops out of full
    hold_nx   = (tx_cnt == FULL && tx_cnt_nx != FULL) ? 2'(TXE_HOLD) :
                hold_cnt != '0 ? hold_cnt - 2'd1 : '0;
  end
  always_ff @(posedge ft_clkout) begin
    if (rx_push) rx_mem[rx_wp] <= host_wdata;
    if (tx_push) tx_mem[tx_wp] <= ft.ft_bus_in;
  end
  always_ff @(posedge ft_clkout) begin
    if (rst) begin
      rx_wp        <= '0;
      rx_rp        <= '0;
      tx_wp        <= '0;
      tx_rp        <= '0;
      rx_cnt       <= '0;
      tx_cnt       <= '0;
      hold_cnt     <= '0;
      ft.ft_rxf_n  <= 1'b1;
      ft.ft_txe_n  <= 1'b1;
      ft.ft_bus_oe <= 1'b0;
      host_flush   <= 1'b0;
      err          <= '0;
    end else begin
      rx_wp        <= rx_wp + AW'(rx_push);
      rx_rp        <= rx_rp + AW'(rx_pop);
      tx_wp        <= tx_wp + AW'(tx_push);
      tx_rp        <= tx_rp + AW'(tx_pop);
      rx_cnt       <= rx_cnt_nx;
      tx_cnt       <= tx_cnt_nx;
      hold_cnt     <= hold_nx;
      ft.ft_rxf_n  <= rx_cnt_nx == '0;
      ft.ft_txe_n  <= tx_cnt_nx == FULL || hold_nx != '0;
      ft.ft_bus_oe <= ~ft.ft_oe_n;
      host_flush   <= ~ft.ft_siwu_n;
      err          <= err | {~ft.ft_rd_n & ~ft.ft_wr_n, ~ft.ft_wr_n & ft.ft_txe_n, ~ft.ft_rd_n & ft.ft_rxf_n};
    end
  end
endmodule
